// File: rtl/systolic_mxu.sv
// systolic_mxu: output-stationary N x N systolic array computing C = A x B over K streamed beats
// Ports: clk/rst (async active-low) | start, abort control | in_valid/in_ready/in_last with a_col, b_row
//        operand beats | out_valid/out_ready with out_row, out_idx result rows | busy, done status
module systolic_mxu #(
  parameter int N      = 4,
  parameter int DW     = 32,
  parameter int AW     = 64,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N*DW-1:0]        a_col,
  input  logic [N*DW-1:0]        b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*AW-1:0]        out_row,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   busy,
  output logic                   done
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(2*N);
  localparam logic [1:0] IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, OUT = 2'd3;

  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          fire, clr, flush, run;
  logic [DW:0]   wa [N];
  logic [DW:0]   nb [N];
  logic [DW:0]   ah_q [N][N];
  logic [DW:0]   bv_q [N][N];
  logic [AW-1:0] acc_q [N][N];

  assign fire      = in_valid & in_ready;
  assign clr       = (st_q == IDLE) & start & ~abort;
  // Abort and a fresh start both empty the operand pipeline so in-flight beats never leak into a run.
  assign flush     = abort | clr;
  assign run       = (st_q == FEED) | (st_q == DRAIN);
  assign in_ready  = st_q == FEED;
  assign out_valid = st_q == OUT;
  assign busy      = st_q != IDLE;
  assign done      = done_q;
  assign out_idx   = idx_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (abort) st_d = IDLE;
    else if (st_q == IDLE) st_d = start ? FEED : IDLE;
    else if (st_q == FEED) begin
      if (fire & in_last) begin
        st_d  = DRAIN;
        cnt_d = '0;
      end
    end else if (st_q == DRAIN) begin
      // The last beat reaches PE(N-1,N-1) 2N-2 cycles after acceptance.
      if (cnt_q == CW'(2*N-2)) begin
        st_d  = OUT;
        idx_d = '0;
      end else cnt_d = cnt_q + CW'(1);
    end else if (out_ready) begin
      if (idx_q == IW'(N-1)) begin
        st_d   = IDLE;
        done_d = 1'b1;
      end else idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) out_row[j*AW +: AW] = out_valid ? acc_q[idx_q][j] : '0;
  end

  // Input skew: lane i is delayed i cycles so that beat k meets in PE(i,j) at cycle k+i+j.
  for (genvar i = 0; i < N; i++) begin : g_sk
    logic [DW:0] sa, sb;
    assign sa = {fire, a_col[i*DW +: DW]};
    assign sb = {fire, b_row[i*DW +: DW]};
    if (i == 0) begin : g_0
      assign wa[i] = sa;
      assign nb[i] = sb;
    end else begin : g_d
      logic [DW:0] da_q [i];
      logic [DW:0] db_q [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < i; d++) begin
            da_q[d] <= '0;
            db_q[d] <= '0;
          end
        end else begin
          da_q[0] <= flush ? '0 : sa;
          db_q[0] <= flush ? '0 : sb;
          for (int d = 1; d < i; d++) begin
            da_q[d] <= flush ? '0 : da_q[d-1];
            db_q[d] <= flush ? '0 : db_q[d-1];
          end
        end
      end
      assign wa[i] = da_q[i-1];
      assign nb[i] = db_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      logic [DW:0]   ai, bi;
      logic [AW-1:0] ax, bx;
      if (j == 0) begin : g_w
        assign ai = wa[i];
      end else begin : g_e
        assign ai = ah_q[i][j-1];
      end
      if (i == 0) begin : g_n
        assign bi = nb[j];
      end else begin : g_s
        assign bi = bv_q[i-1][j];
      end
      // Extending both operands to AW before multiplying gives the product modulo 2^AW in either mode.
      assign ax = {{(AW-DW){SIGNED != 0 && ai[DW-1]}}, ai[DW-1:0]};
      assign bx = {{(AW-DW){SIGNED != 0 && bi[DW-1]}}, bi[DW-1:0]};
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ah_q[i][j]  <= '0;
          bv_q[i][j]  <= '0;
          acc_q[i][j] <= '0;
        end else begin
          ah_q[i][j]  <= flush ? '0 : ai;
          bv_q[i][j]  <= flush ? '0 : bi;
          acc_q[i][j] <= clr ? '0 : (run && ai[DW] && bi[DW]) ? acc_q[i][j] + ax * bx : acc_q[i][j];
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_mxu.sv
// tb_systolic_mxu: scoreboard bench driving an unsigned (AW=16) and a signed (AW=32) array with shared stimulus
module tb_systolic_mxu;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MK = 8;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [N*DW-1:0] a_col = '0, b_row = '0;
  logic rdy0, rdy1, ov0, ov1, bs0, bs1, dn0, dn1;
  logic [1:0] ix0, ix1;
  logic [N*16-1:0] row0;
  logic [N*32-1:0] row1;

  always #5 clk = ~clk;

  systolic_mxu #(.N(N), .DW(DW), .AW(16), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid), .in_ready(rdy0),
    .in_last(in_last), .a_col(a_col), .b_row(b_row), .out_valid(ov0), .out_ready(out_ready),
    .out_row(row0), .out_idx(ix0), .busy(bs0), .done(dn0));
  systolic_mxu #(.N(N), .DW(DW), .AW(32), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid), .in_ready(rdy1),
    .in_last(in_last), .a_col(a_col), .b_row(b_row), .out_valid(ov1), .out_ready(out_ready),
    .out_row(row1), .out_idx(ix1), .busy(bs1), .done(dn1));

  typedef struct {int idx; logic [127:0] row;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int nchk = 0, nfail = 0;
  logic [7:0] Am [MK][N];
  logic [7:0] Bm [MK][N];

  logic ov [2], irdy [2], bsy [2], dn [2];
  logic [1:0] oidx [2];
  logic [127:0] orow [2];
  assign ov[0] = ov0;   assign ov[1] = ov1;
  assign irdy[0] = rdy0; assign irdy[1] = rdy1;
  assign bsy[0] = bs0;  assign bsy[1] = bs1;
  assign dn[0] = dn0;   assign dn[1] = dn1;
  assign oidx[0] = ix0; assign oidx[1] = ix1;
  assign orow[0] = {64'b0, row0};
  assign orow[1] = row1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // C[r][j] = sum_k A[r][k]*B[k][j], reduced to the accumulator width of each instance.
  function automatic logic [127:0] exp_row(input int r, input int K, input bit sg);
    logic [127:0] v = '0;
    longint s;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < K; k++)
        s += sg ? longint'($signed(Am[k][r])) * longint'($signed(Bm[k][j]))
                : longint'(Am[k][r]) * longint'(Bm[k][j]);
      if (sg) v[j*32 +: 32] = s[31:0];
      else v[j*16 +: 16] = s[15:0];
    end
    return v;
  endfunction

  bit pst [2], pl [2], pov [2];
  logic [127:0] prow [2];
  logic [1:0] pidx [2];
  int dcnt [2];

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        chk("reset_ctrl", 128'({bsy[d], dn[d], irdy[d], ov[d], oidx[d]}), '0);
        chk("reset_row", orow[d], '0);
        pst[d] = 0; pl[d] = 0; pov[d] = 0; dcnt[d] = 0;
      end else begin
        chk("done", 128'(dn[d]), 128'(pl[d]));
        if (pst[d]) begin
          chk("hold_valid", 128'(ov[d]), 128'(1'b1));
          chk("hold_row", orow[d], prow[d]);
          chk("hold_idx", 128'(oidx[d]), 128'(pidx[d]));
        end
        if (!ov[d]) chk("row_zero_when_invalid", orow[d], '0);
        pl[d] = 0;
        if (ov[d] && out_ready) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            nchk++; nfail++;
            $display("FAIL unexpected_row: dut%0d presented idx %0d, expected no row", d, oidx[d]);
          end else begin
            if (d == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk("row_idx", 128'(oidx[d]), 128'(e.idx));
            chk("row_data", orow[d], e.row);
            pl[d] = e.idx == N-1;
          end
        end
        if (!bsy[d]) dcnt[d] = 0;
        else if (!irdy[d] && !ov[d]) dcnt[d]++;
        if (ov[d] && !pov[d]) begin
          chk("drain_len", 128'(dcnt[d]), 128'(2*N-1));
          dcnt[d] = 0;
        end
        pov[d] = ov[d]; pst[d] = ov[d] && !out_ready; prow[d] = orow[d]; pidx[d] = oidx[d];
      end
    end
    if (!rst) begin
      q0.delete();
      q1.delete();
    end
  end

  task automatic rnd_fill();
    for (int k = 0; k < MK; k++)
      for (int i = 0; i < N; i++) begin
        Am[k][i] = 8'($urandom);
        Bm[k][i] = 8'($urandom);
      end
  endtask

  // bub: 0 gap-free, 1 valid on every third cycle, 2 random; srow: row stalled 3 cycles;
  // sbusy: pulse start while draining; abort_at: abort after that many beats; rst_row: reset at that row.
  task automatic run(input int K, input int bub, input int srow, input bit sbusy, input int abort_at, input int rst_row);
    int k = 0, cyc = 0, w, stall;
    bit acc;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (k < K) begin
      in_valid = (bub == 0) || (bub == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 1) == 1));
      in_last = in_valid ? (k == K-1) : ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = in_valid ? Am[k][i] : 8'($urandom);
        b_row[i*DW +: DW] = in_valid ? Bm[k][i] : 8'($urandom);
      end
      @(negedge clk); acc = in_valid && rdy0;
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
      if (acc && k == K)
        for (int r = 0; r < N; r++) begin
          q0.push_back('{r, exp_row(r, K, 1'b0)});
          q1.push_back('{r, exp_row(r, K, 1'b1)});
        end
      if (abort_at > 0 && k == abort_at) begin
        in_valid = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("abort_idle", 128'({bs0, bs1}), '0);
        return;
      end
      if (cyc > 100) begin
        nchk++; nfail++;
        $display("FAIL feed_timeout: accepted %0d beats, expected %0d", k, K);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (sbusy) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int r = 0; r < N; r++) begin
      w = 0;
      while (!ov0 && w < 100) begin @(posedge clk); #1; w++; end
      if (!ov0) begin
        nchk++; nfail++;
        $display("FAIL out_timeout: out_valid low at row %0d, expected high", r);
        return;
      end
      if (r == rst_row) begin
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        return;
      end
      stall = (r == srow) ? 3 : (bub == 2 ? $urandom_range(0, 2) : 0);
      out_ready = 1'b0;
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < MK; k++)
      for (int i = 0; i < N; i++) begin
        Am[k][i] = (k == i) ? 8'd1 : 8'd0;
        Bm[k][i] = 8'(4*k + i);
      end
    run(4, 0, -1, 1'b0, 0, -1);
    for (int i = 0; i < N; i++) begin Am[0][i] = 8'hFD; Bm[0][i] = 8'd5; end
    run(1, 0, -1, 1'b0, 0, -1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin Am[k][i] = 8'hFF; Bm[k][i] = 8'hFF; end
    run(2, 0, -1, 1'b0, 0, -1);
    rnd_fill();
    run(4, 1, 1, 1'b0, 0, -1);
    rnd_fill();
    run(4, 0, -1, 1'b0, 2, -1);
    rnd_fill();
    run(2, 0, -1, 1'b0, 0, -1);
    rnd_fill();
    run(3, 2, -1, 1'b1, 0, 2);
    repeat (6) begin
      rnd_fill();
      run($urandom_range(1, MK), 2, $urandom_range(0, N-1), 1'b1, 0, -1);
    end
    repeat (5) @(posedge clk);
    #1 chk("queue_empty", 128'(q0.size() + q1.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
